bcd_conv_arbiter: RTL and testbench

- Shares one combinational binary-to-BCD converter (bin2bcd) between several display channels, such as score, timer and lives.
- Round-robin arbitration across channels; req/ack handshake per channel.
- Latches each channel's converted BCD digits and sign flag into per-channel result registers.
- The 7-segment scanner reads those registers.
- Sits between game-logic counters and the display multiplexer in the disp/ hierarchy.

---
 rtl/disp_pkg.sv | 20 ++
 rtl/bin2bcd.sv | 29 ++
 rtl/rr_pick.sv | 28 ++
 rtl/bcd_conv_arbiter.sv | 150 +++++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// Shared display-path definitions: arbiter FSM states, sign polarity and
// the BCD result width helper.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        WRITE  = 2'd3
    } disp_arb_state_t;

    // Sign flag value meaning "non-negative".
    localparam logic SGN_POS = 1'b1;

    // Each BCD digit occupies one nibble.
    function automatic int bcd_width(input int digits);
        return digits * 4;
    endfunction

endpackage

// File: rtl/bin2bcd.sv
// Combinational two's-complement binary to sign + BCD magnitude converter.
// The magnitude is split into decimal digits, least significant nibble first.
module bin2bcd #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
) (
    input  logic [WIDTH-1:0]    bin,
    output logic [DIGITS*4-1:0] bcd,
    output logic                sgn
);

    logic [WIDTH-1:0] mag;
    logic [31:0]      rem_var;

    assign sgn = ~bin[WIDTH-1];
    // The most negative operand negates to itself, which reads correctly as unsigned.
    assign mag = bin[WIDTH-1] ? (~bin + 1'b1) : bin;

    // Peel off decimal digits by repeated division by ten.
    always_comb begin
        bcd     = '0;
        rem_var = 32'(mag);
        for (int d = 0; d < DIGITS; d++) begin
            bcd[d*4 +: 4] = 4'(rem_var % 32'd10);
            rem_var       = rem_var / 32'd10;
        end
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// above ptr, wrapping from the top channel back to channel 0.
module rr_pick #(
    parameter int CHANNELS = 4,
    parameter int PTR_W    = 2
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [PTR_W-1:0]    ptr,
    output logic [PTR_W-1:0]    grant,
    output logic                any
);

    int idx;

    // Scan from farthest to nearest offset so the nearest set request wins.
    always_comb begin
        grant = ptr;
        any   = |req;
        idx   = 0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % CHANNELS;
            if (req[idx]) begin
                grant = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one external binary-to-BCD converter among
// display channels, with per-channel registered results for the scanner.
// Optional macro BCD_ARB_CACHE_EN: skip the converter when a channel
// re-requests the operand it last converted.
module bcd_conv_arbiter
    import disp_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int WIDTH    = 6,
    parameter  int DIGITS   = 2,
    localparam int BCD_W    = bcd_width(DIGITS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS*WIDTH-1:0] bin_flat,
    output logic [CHANNELS-1:0]       ack,
    output logic [CHANNELS*BCD_W-1:0] bcd_flat,
    output logic [CHANNELS-1:0]       sgn,
    output logic [CHANNELS-1:0]       rd_valid,
    output logic [WIDTH-1:0]          conv_bin,
    input  logic [BCD_W-1:0]          conv_bcd,
    input  logic                      conv_sgn,
    output logic                      busy
);

    localparam int PTR_W = $clog2(CHANNELS);

    disp_arb_state_t  state_reg, state_next;
    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] grant_reg;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_any;
    logic [WIDTH-1:0] conv_bin_reg;
    logic [WIDTH-1:0] bin_arr [CHANNELS];
    logic             hit;
    logic             skip_write;

    rr_pick #(
        .CHANNELS (CHANNELS),
        .PTR_W    (PTR_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .grant (pick_idx),
        .any   (pick_any)
    );

`ifdef BCD_ARB_CACHE_EN
    logic [WIDTH-1:0] last_bin_arr [CHANNELS];
    logic             skip_reg;

    // A repeat of the last converted operand needs no new conversion.
    assign hit        = rd_valid[pick_idx] && (bin_arr[pick_idx] == last_bin_arr[pick_idx]);
    assign skip_write = skip_reg;
`else
    assign hit        = 1'b0;
    assign skip_write = 1'b0;
`endif

    // Next-state logic: fixed LOAD/SETTLE margin unless the cache short-circuits to WRITE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pick_any) state_next = hit ? WRITE : LOAD;
            LOAD:    state_next = SETTLE;
            SETTLE:  state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, grant capture, operand capture and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            grant_reg    <= '0;
            conv_bin_reg <= '0;
`ifdef BCD_ARB_CACHE_EN
            skip_reg     <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && pick_any) begin
                grant_reg <= pick_idx;
                // Operand is frozen here so later bin_flat changes cannot leak in.
                if (!hit) begin
                    conv_bin_reg <= bin_arr[pick_idx];
                end
`ifdef BCD_ARB_CACHE_EN
                skip_reg <= hit;
`endif
            end
            if (state_reg == WRITE) begin
                ptr_reg <= (grant_reg == PTR_W'(CHANNELS - 1)) ? '0 : grant_reg + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [BCD_W-1:0] bcd_reg;
            logic             sgn_reg;
            logic             valid_reg;
            logic             wr_en;

            assign bin_arr[gi] = bin_flat[gi*WIDTH +: WIDTH];
            assign ack[gi]     = (state_reg == WRITE) && (grant_reg == PTR_W'(gi));
            assign wr_en       = ack[gi] && !skip_write;

            // Per-channel result latch, written once per completed conversion.
            always_ff @(posedge clk) begin
                if (rst) begin
                    bcd_reg   <= '0;
                    sgn_reg   <= SGN_POS;
                    valid_reg <= 1'b0;
                end else if (wr_en) begin
                    bcd_reg   <= conv_bcd;
                    sgn_reg   <= conv_sgn;
                    valid_reg <= 1'b1;
                end
            end

`ifdef BCD_ARB_CACHE_EN
            logic [WIDTH-1:0] last_bin_reg;

            // Remember the operand behind the currently stored result.
            always_ff @(posedge clk) begin
                if (rst) begin
                    last_bin_reg <= '0;
                end else if (wr_en) begin
                    last_bin_reg <= conv_bin_reg;
                end
            end

            assign last_bin_arr[gi] = last_bin_reg;
`endif

            assign bcd_flat[gi*BCD_W +: BCD_W] = bcd_reg;
            assign sgn[gi]                     = sgn_reg;
            assign rd_valid[gi]                = valid_reg;
        end
    endgenerate

    assign conv_bin = conv_bin_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter with a real bin2bcd on the converter
// ports. Expected results are queued on request and checked on each ack.
module tb_bcd_conv_arbiter;

    localparam int CH = 4;
    localparam int W  = 6;
    localparam int D  = 2;
    localparam int BW = D * 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CH-1:0]     req = '0;
    logic [CH*W-1:0]   bin_flat = '0;
    logic [CH-1:0]     ack;
    logic [CH*BW-1:0]  bcd_flat;
    logic [CH-1:0]     sgn;
    logic [CH-1:0]     rd_valid;
    logic [W-1:0]      conv_bin;
    logic [BW-1:0]     conv_bcd;
    logic              conv_sgn;
    logic              busy;

    typedef struct {
        int         ch;
        logic [7:0] bcd;
        logic       sgn;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    bit   mon_en       = 1'b0;

    always #5 clk = ~clk;

    bcd_conv_arbiter #(.CHANNELS(CH), .WIDTH(W), .DIGITS(D)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .bin_flat (bin_flat),
        .ack      (ack),
        .bcd_flat (bcd_flat),
        .sgn      (sgn),
        .rd_valid (rd_valid),
        .conv_bin (conv_bin),
        .conv_bcd (conv_bcd),
        .conv_sgn (conv_sgn),
        .busy     (busy)
    );

    bin2bcd #(.WIDTH(W), .DIGITS(D)) u_conv (
        .bin (conv_bin),
        .bcd (conv_bcd),
        .sgn (conv_sgn)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_bcd(input int v);
        int m;
        m = (v < 0) ? -v : v;
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic set_bin(input int ch, input int v);
        bin_flat[ch*W +: W] = W'(v);
    endtask

    task automatic push_exp(input int ch, input int v);
        exp_t e;
        e.ch  = ch;
        e.bcd = model_bcd(v);
        e.sgn = (v >= 0);
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int budget, output int n, output logic [CH-1:0] a);
        n = 0;
        a = '0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            a = ack;
            if (a != '0) break;
        end
        check("ack_seen", 32'(a != '0), 32'd1);
    endtask

    // Issue one request at a negedge, expect ack after lat cycles, then release it.
    task automatic run_one(input int ch, input int v, input int lat);
        int            n;
        logic [CH-1:0] a;
        set_bin(ch, v);
        push_exp(ch, v);
        req[ch] = 1'b1;
        wait_ack(8, n, a);
        check("latency", 32'(n), 32'(lat));
        check("ack_ch", 32'(a), 32'(1 << ch));
        req[ch] = 1'b0;
        @(negedge clk);
    endtask

    // Scoreboard: pop on ack, verify the registered result one cycle later.
    exp_t cur;
    bit   pend = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (pend) begin
                pend = 1'b0;
                check("res_bcd", 32'(bcd_flat[cur.ch*BW +: BW]), 32'(cur.bcd));
                check("res_sgn", 32'(sgn[cur.ch]), 32'(cur.sgn));
                check("res_valid", 32'(rd_valid[cur.ch]), 32'd1);
            end
            if (ack != '0) begin
                if (sb.size() == 0) begin
                    check("ack_unexpected", 32'(ack), 32'd0);
                end else begin
                    cur = sb.pop_front();
                    check("sb_ack_ch", 32'(ack), 32'(1 << cur.ch));
                    $display("[TB] ack ch%0d expect bcd=%h sgn=%b", cur.ch, cur.bcd, cur.sgn);
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_bcd"}, 32'(bcd_flat), 32'd0);
        check({tag, "_sgn"}, 32'(sgn), 32'hf);
        check({tag, "_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_conv_bin"}, 32'(conv_bin), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            n;
        logic [CH-1:0] a;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");
        mon_en = 1'b1;

        // Single request ch0 = 23: busy in cycles 1..3, ack in cycle 3.
        set_bin(0, 23);
        push_exp(0, 23);
        req[0] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("t1_busy", 32'(busy), 32'd1);
            check("t1_ack", 32'(ack), (i == 3) ? 32'd1 : 32'd0);
        end
        req[0] = 1'b0;
        @(negedge clk);
        check("t1_idle", 32'(busy), 32'd0);

        // Negative operand on ch1.
        run_one(1, -5, 3);

        // Reset while ch3 is in SETTLE: conversion abandoned, no ack.
        set_bin(3, -20);
        req[3] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_settle_busy", 32'(busy), 32'd1);
        rst    = 1'b1;
        req[3] = 1'b0;
        @(negedge clk);
        check_reset_state("midrst");
        rst = 1'b0;
        run_one(3, -20, 3);

        // All channels requesting continuously from ptr = 0.
        set_bin(0, 1);
        set_bin(1, -2);
        set_bin(2, 30);
        set_bin(3, -32);
        push_exp(0, 1);
        push_exp(1, -2);
        push_exp(2, 30);
        push_exp(3, -32);
        push_exp(0, 1);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(8, n, a);
            check("rr_gap", 32'(n), (k == 0) ? 32'd3 : 32'd4);
            check("rr_order", 32'(a), 32'(1 << (k % 4)));
            if (k == 3) req[3:1] = 3'b000;
            if (k == 4) req[0] = 1'b0;
        end
        @(negedge clk);

        // Operand captured at grant: change during LOAD is ignored.
        set_bin(2, 10);
        push_exp(2, 10);
        req[2] = 1'b1;
        @(negedge clk);
        set_bin(2, 31);
        wait_ack(8, n, a);
        check("cap_latency", 32'(n), 32'd2);
        check("cap_ack", 32'(a), 32'(1 << 2));
        req[2] = 1'b0;
        @(negedge clk);
        run_one(2, 31, 3);

        // Repeat operand: cached fast path when enabled, full path otherwise.
        run_one(0, 17, 3);
`ifdef BCD_ARB_CACHE_EN
        run_one(0, 17, 1);
        check("cache_conv_bin", 32'(conv_bin), 32'd17);
`else
        run_one(0, 17, 3);
`endif
        run_one(0, 18, 3);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
